// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: bus addresses,
// serializer state encoding, default baud divisor and status-word packing.
package uart_tx_fifo_pkg;

   localparam logic [31:0] UART_ADDR        = 32'h0000_0400;
   localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0404;

   // 100 MHz sysclk / 115200 baud
   localparam int UART_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   // Load-mux word at UART_STATUS_ADDR; level is zero-extended by the caller.
   function automatic logic [31:0] uart_status_word(input logic       overflow,
                                                    input logic       tx_busy,
                                                    input logic       full,
                                                    input logic       empty,
                                                    input logic [7:0] level);
      return {20'd0, overflow, tx_busy, full, empty, level};
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Register-array FIFO; level is the only occupancy state, pointers carry no
// wrap bit. Pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     sysclk,
   input  logic                     cpu_resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge sysclk or posedge cpu_resetn) begin
      if (cpu_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage is never reset; resetting the pointers and level discards it.
   always_ff @(posedge sysclk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU stores fill a FIFO, a serializer FSM
// drains it back-to-back. uart_tx is registered from the next-state values.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                   sysclk,
   input  logic                   cpu_resetn,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   uart_tx,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   tx_busy,
   output logic                   overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   uart_state_e state, state_next;
   logic [BW-1:0] baud_cnt;
   logic          baud_last;
   logic [2:0]    bit_idx;
   logic [7:0]    shift, shift_next;
   logic [7:0]    fifo_data;
   logic          pop;
   logic          tx_next;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .push       (wr_en),
      .push_data  (wr_data),
      .pop        (pop),
      .pop_data   (fifo_data),
      .level      (level),
      .full       (full),
      .empty      (empty)
   );

   assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   assign tx_busy   = (state != UART_IDLE);

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      shift_next = shift;
      case (state)
         UART_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = UART_START;
            end
         end
         UART_START: begin
            if (baud_last) state_next = UART_DATA;
         end
         UART_DATA: begin
            if (baud_last) begin
               shift_next = shift >> 1;
               if (bit_idx == 3'd7) state_next = UART_STOP;
            end
         end
         UART_STOP: begin
            if (baud_last) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = UART_START;
               end else begin
                  state_next = UART_IDLE;
               end
            end
         end
         default: state_next = UART_IDLE;
      endcase
      if (pop) shift_next = fifo_data;

      // Line level the FSM will present after this edge.
      case (state_next)
         UART_START: tx_next = 1'b0;
         UART_DATA:  tx_next = shift_next[0];
         default:    tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge sysclk or posedge cpu_resetn) begin
      if (cpu_resetn) begin
         state    <= UART_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         uart_tx  <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state   <= state_next;
         uart_tx <= tx_next;
         if (state_next != state || baud_last) baud_cnt <= '0;
         else                                  baud_cnt <= baud_cnt + 1'b1;
         if (state_next == UART_DATA && state != UART_DATA) bit_idx <= '0;
         else if (state == UART_DATA && baud_last)          bit_idx <= bit_idx + 1'b1;
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      shift <= shift_next;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DEPTH=4, CLKS_PER_BIT=4.
module tb_uart_tx_fifo;

   logic       sysclk = 1'b0;
   logic       cpu_resetn = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       uart_tx, full, empty, tx_busy, overflow;
   logic [2:0] level;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   uart_tx_fifo #(
      .DEPTH        (4),
      .CLKS_PER_BIT (4)
   ) dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .uart_tx    (uart_tx),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .tx_busy    (tx_busy),
      .overflow   (overflow)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   // Receive one frame starting at cycle t_known, or poll for the start bit
   // when t_known < 0. Samples the middle of each bit cell.
   task automatic rx_frame(input int t_known, output logic [7:0] d,
                           output int t0, output bit ok);
      int n;
      d  = 8'h00;
      ok = 1'b1;
      t0 = t_known;
      if (t_known < 0) begin
         n = 0;
         while (uart_tx !== 1'b0 && n < 400) begin
            step();
            n++;
         end
         t0 = cyc;
         if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
         end
      end
      if (cyc <= t0 + 2) begin
         step(t0 + 2 - cyc);
         if (uart_tx !== 1'b0) ok = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
         step(t0 + 6 + 4 * k - cyc);
         d[k] = uart_tx;
      end
      step(t0 + 38 - cyc);
      if (uart_tx !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset();
      cpu_resetn = 1'b1;
      step(3);
      n_cmp++;
      if ({uart_tx, empty, full, level, tx_busy, overflow} !== 8'b1_1_0_000_0_0) begin
         n_bad++;
         $display("FAIL reset_values: got {tx,empty,full,level,busy,ovf}=%b expected 11000000",
                  {uart_tx, empty, full, level, tx_busy, overflow});
      end
      cpu_resetn = 1'b0;
      step(2);
      n_cmp++;
      if ({uart_tx, empty, tx_busy, level} !== 6'b1_1_0_000) begin
         n_bad++;
         $display("FAIL reset_release_idle: got {tx,empty,busy,level}=%b expected 110000",
                  {uart_tx, empty, tx_busy, level});
      end
   endtask

   task automatic test_single();
      logic [9:0] fb;
      int bad_at;
      fb = {1'b1, 8'h55, 1'b0};
      push(8'h55);
      n_cmp++;
      if (level !== 3'd1 || uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL single_after_write: level=%0d tx=%b expected level=1 tx=1", level, uart_tx);
      end
      step();
      n_cmp++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1 || level !== 3'd0) begin
         n_bad++;
         $display("FAIL single_first_bit: tx=%b busy=%b level=%0d expected tx=0 busy=1 level=0",
                  uart_tx, tx_busy, level);
      end
      bad_at = -1;
      for (int i = 0; i < 40; i++) begin
         if (uart_tx !== fb[i / 4] && bad_at < 0) bad_at = i;
         step();
      end
      n_cmp++;
      if (bad_at >= 0) begin
         n_bad++;
         $display("FAIL single_waveform: first wrong cycle=%0d expected none", bad_at);
      end
      n_cmp++;
      if (tx_busy !== 1'b0 || empty !== 1'b1 || uart_tx !== 1'b1) begin
         n_bad++;
         $display("FAIL single_end: busy=%b empty=%b tx=%b expected busy=0 empty=1 tx=1",
                  tx_busy, empty, uart_tx);
      end
   endtask

   task automatic test_burst();
      logic [7:0] d;
      int t1, t2, t3, tx;
      bit ok;
      push(8'hA1);
      t1 = cyc + 1;
      n_cmp++;
      if (level !== 3'd1) begin n_bad++; $display("FAIL burst_level1: got %0d expected 1", level); end
      push(8'hB2);
      n_cmp++;
      if (level !== 3'd1) begin n_bad++; $display("FAIL burst_level2: got %0d expected 1", level); end
      push(8'hC3);
      n_cmp++;
      if (level !== 3'd2) begin n_bad++; $display("FAIL burst_level3: got %0d expected 2", level); end
      rx_frame(t1, d, tx, ok);
      n_cmp++;
      if (!ok || d !== 8'hA1) begin n_bad++; $display("FAIL burst_frame1: got %h ok=%0d expected a1", d, ok); end
      rx_frame(-1, d, t2, ok);
      n_cmp++;
      if (!ok || d !== 8'hB2 || t2 - t1 !== 40 || level !== 3'd1) begin
         n_bad++;
         $display("FAIL burst_frame2: got %h gap=%0d level=%0d expected b2 gap=40 level=1", d, t2 - t1, level);
      end
      rx_frame(-1, d, t3, ok);
      n_cmp++;
      if (!ok || d !== 8'hC3 || t3 - t2 !== 40 || level !== 3'd0) begin
         n_bad++;
         $display("FAIL burst_frame3: got %h gap=%0d level=%0d expected c3 gap=40 level=0", d, t3 - t2, level);
      end
      step(10);
   endtask

   task automatic test_simultaneous();
      logic [7:0] d;
      int t1, t2, t3, tx;
      bit ok;
      push(8'h3C);
      t1 = cyc + 1;
      push(8'h5A);
      n_cmp++;
      if (level !== 3'd1) begin n_bad++; $display("FAIL simul_pre_level: got %0d expected 1", level); end
      rx_frame(t1, d, tx, ok);
      n_cmp++;
      if (!ok || d !== 8'h3C) begin n_bad++; $display("FAIL simul_frame1: got %h ok=%0d expected 3c", d, ok); end
      step();
      wr_en   = 1'b1;
      wr_data = 8'h96;
      step();
      wr_en   = 1'b0;
      n_cmp++;
      if (level !== 3'd1 || uart_tx !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_stop_edge: level=%0d tx=%b expected level=1 tx=0", level, uart_tx);
      end
      rx_frame(-1, d, t2, ok);
      n_cmp++;
      if (!ok || d !== 8'h5A || t2 - t1 !== 40) begin
         n_bad++;
         $display("FAIL simul_frame2: got %h gap=%0d expected 5a gap=40", d, t2 - t1);
      end
      rx_frame(-1, d, t3, ok);
      n_cmp++;
      if (!ok || d !== 8'h96 || t3 - t2 !== 40) begin
         n_bad++;
         $display("FAIL simul_frame3: got %h gap=%0d expected 96 gap=40", d, t3 - t2);
      end
      step(10);
      n_cmp++;
      if (empty !== 1'b1 || tx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_drained: empty=%b busy=%b expected 1 0", empty, tx_busy);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] d;
      int t1, tx, lows;
      bit ok;
      n_cmp++;
      if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_before: got %b expected 0", overflow); end
      push(8'h11);
      t1 = cyc + 1;
      push(8'h22);
      push(8'h33);
      push(8'h44);
      push(8'h55);
      n_cmp++;
      if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_full: full=%b level=%0d ovf=%b expected 1 4 0", full, level, overflow);
      end
      push(8'h66);
      n_cmp++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         n_bad++;
         $display("FAIL ovf_dropped: ovf=%b level=%0d expected 1 4", overflow, level);
      end
      for (int i = 0; i < 5; i++) begin
         rx_frame((i == 0) ? t1 : -1, d, tx, ok);
         n_cmp++;
         if (!ok || d !== exp_b[i]) begin
            n_bad++;
            $display("FAIL ovf_frame%0d: got %h ok=%0d expected %h", i + 1, d, ok, exp_b[i]);
         end
      end
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (uart_tx !== 1'b1) lows++;
      end
      n_cmp++;
      if (lows != 0 || empty !== 1'b1 || overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_no_sixth: low_cycles=%0d empty=%b ovf=%b expected 0 1 1", lows, empty, overflow);
      end
   endtask

   task automatic test_reset_mid_data();
      int lows;
      push(8'hF0);
      push(8'h0F);
      step(17);
      n_cmp++;
      if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre_bit3: tx=%b busy=%b expected 0 1", uart_tx, tx_busy);
      end
      #2;
      cpu_resetn = 1'b1;
      #1;
      n_cmp++;
      if (uart_tx !== 1'b1 || level !== 3'd0 || overflow !== 1'b0 || empty !== 1'b1 || tx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async: tx=%b level=%0d ovf=%b empty=%b busy=%b expected 1 0 0 1 0",
                  uart_tx, level, overflow, empty, tx_busy);
      end
      step(2);
      cpu_resetn = 1'b0;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      n_cmp++;
      if (lows != 0) begin
         n_bad++;
         $display("FAIL rst_no_frame: active cycles=%0d expected 0", lows);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_simultaneous();
      test_overflow();
      test_reset_mid_data();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter that sits downstream of the CPU store path. It replaces the unbuffered `uart` instance. A store to `UART_ADDR` pushes one byte into a DEPTH-entry FIFO. A serializer FSM drains the FIFO as 8N1 frames on `uart_tx`. Status outputs (`full`, `empty`, `level`, `overflow`) are wired into the load mux at `UART_STATUS_ADDR`, so software can poll before writing.

## Interface
Parameters:
- `DEPTH`, 16: number of FIFO entries; must be a power of two, minimum 2.
- `CLKS_PER_BIT`, 868: `sysclk` cycles per bit (100 MHz / 115200); minimum 2.

Ports:
- `sysclk`  in  1  system clock.
- `cpu_resetn`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  push request, one per store; driven by `(alu_result==UART_ADDR) && is_store`.
- `wr_data`  in  8  byte to push; driven by `w_data_memo[7:0]`.
- `uart_tx`  out  1  serial line, idle high, registered.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  clog2(DEPTH)+1  current entry count.
- `tx_busy`  out  1  FSM not in IDLE.
- `overflow`  out  1  sticky; set when a push is dropped.

## Operation
- Push:
  - `wr_en=1 && !full`: `wr_data` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
  - `wr_en=1 && full`: the byte is dropped, `overflow` is set to 1 and held until reset.
- Pop: happens only on an FSM transition into START. The byte at `rd_ptr` is loaded into an 8-bit shift register, and `rd_ptr` increments modulo DEPTH.
- Simultaneous push and pop: both take effect and `level` is unchanged.
  - Push into an empty FIFO does not bypass; the byte is popped at the next edge at the earliest.
  - Push while full is dropped even if a pop happens in the same cycle, because `full` is the registered value.
- `level` = pushes − pops. `full`/`empty` are derived from `level`. The pointers carry no wrap bit.
- FSM states:
  - IDLE: `uart_tx`=1. If `!empty`, pop and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. At the end: if `!empty`, pop and go straight to START; else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1, wraps to 0, and is cleared on every state change.
- Reset values: `uart_tx`=1, `empty`=1, `full`=0, `level`=0, `tx_busy`=0, `overflow`=0, state=IDLE, pointers=0.
- Reset mid-frame: the line goes high immediately (asynchronous), and FIFO contents are discarded.

## Timing
- Write accepted at edge E0: `level` updates after E0.
- FSM in IDLE: pops at E1, and `uart_tx` falls after E1. First-bit latency is 1 cycle.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames have no idle gap: start bits fall every 10×CLKS_PER_BIT cycles while the FIFO is non-empty.
- `tx_busy` rises with START and falls on the edge that enters IDLE.
- The CPU issues at most one push per cycle; every `wr_en` cycle counts as a separate push.

## Structure
- `define.vh` holds:
  - `UART_ADDR` and new `UART_STATUS_ADDR`.
  - FSM state encodings `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP` (2 bits).
  - Default `CLKS_PER_BIT`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): a register-array FIFO with push/pop/level/full/empty.
- `uart_tx_fifo` contains `sync_fifo`, the FSM, the baud counter, the bit index, the shift register and the `overflow` flag.
- Status word at `UART_STATUS_ADDR` = {overflow, tx_busy, full, empty, level}, zero-extended, assembled in `top`.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and DEPTH=4.
- Single byte: push 0x55 into an idle FIFO.
  - `uart_tx` falls 1 cycle after the write edge.
  - Line reads 0,1,0,1,0,1,0,1,0,1 (start bit, 0x55 LSB-first, stop bit), each bit held 4 cycles; total 40 cycles.
  - `tx_busy` then 0, `empty`=1.
- Burst: push 0xA1, 0xB2, 0xC3 on consecutive cycles.
  - Three frames back-to-back, start bits exactly 40 cycles apart.
  - `level` sequence 1,1,2, then decrements on each subsequent pop.
- Overflow: push 6 bytes on consecutive cycles.
  - First pop happens after push 1; 4 are queued and `full`=1.
  - Push 6 is dropped and `overflow`=1.
  - Transmitted bytes are pushes 1–5 only.
- Simultaneous: push at the STOP-end edge while `level`=1.
  - Pop and push both occur and `level` stays 1.
  - Next frame starts with no gap.
- Reset mid-DATA: assert `cpu_resetn` during bit 3.
  - `uart_tx`=1 immediately, `level`=0, `overflow`=0.
  - No further frame after release.
